bomb_ctrl: RTL

- Game-logic stage directly upstream of the VGA render stage.
- Owns the bomb lifecycle: place, fuse countdown, blast, cooldown.
- Publishes registered bomb position, visibility and blast-lane indices; the renderer turns these into pixels.
- Flags when the player stands in an active blast lane.
- Advances only on a one-cycle game-tick enable, so all game timing runs in the pixel-clock domain.

---
 rtl/bomb_pkg.sv | 31 +++
 rtl/bomb_ctrl_lane_decode.sv | 34 +++
 rtl/bomb_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared bomb game-logic definitions: FSM state encoding, corridor ranges and
// default tick counts. The render stage imports this package as well, so the
// explosions it draws use exactly the same lanes as the game logic.
package bomb_pkg;

   localparam int unsigned CNT_W     = 8;
   localparam int unsigned NUM_LANES = 5;

   localparam int unsigned FUSE_TICKS_DEF     = 72;
   localparam int unsigned BLAST_TICKS_DEF    = 24;
   localparam int unsigned COOLDOWN_TICKS_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_BLAST    = 2'd2,
      ST_COOLDOWN = 2'd3
   } bomb_state_e;

   typedef enum logic {
      LANE_ROW = 1'b0,
      LANE_COL = 1'b1
   } lane_axis_e;

   // Inclusive corridor ranges; horizontal corridors are indexed by Y, vertical by X
   localparam int unsigned ROW_LO [NUM_LANES] = '{  6, 110, 214, 318, 422};
   localparam int unsigned ROW_HI [NUM_LANES] = '{ 58, 162, 266, 370, 474};
   localparam int unsigned COL_LO [NUM_LANES] = '{  5, 145, 285, 425, 565};
   localparam int unsigned COL_HI [NUM_LANES] = '{ 75, 215, 355, 495, 635};

endpackage

// File: rtl/bomb_ctrl_lane_decode.sv
// lane_decode: combinational coordinate -> corridor lookup.
// Ports:
//   coord    in   CW  coordinate (Y for rows, X for columns)
//   valid_c  out  1   coordinate lies inside one of the corridors
//   idx_c    out  3   index of that corridor, 0 when none matches
module lane_decode
   import bomb_pkg::*;
#(
   parameter int unsigned CW   = 10,
   parameter lane_axis_e  AXIS = LANE_ROW
) (
   input  logic [CW-1:0] coord,
   output logic          valid_c,
   output logic [2:0]    idx_c
);

   logic [31:0] coord_ext;

   assign coord_ext = 32'(coord);

   // Walk from the last lane down so the lowest matching lane is written last
   always_comb begin
      valid_c = 1'b0;
      idx_c   = 3'd0;
      for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
         if ((AXIS == LANE_ROW) ? (coord_ext >= ROW_LO[i] && coord_ext <= ROW_HI[i])
                                : (coord_ext >= COL_LO[i] && coord_ext <= COL_HI[i])) begin
            valid_c = 1'b1;
            idx_c   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: bomb lifecycle (place, fuse, blast, cooldown) feeding the VGA renderer.
// Ports:
//   clk, reset_n           pixel clock, async active-low reset
//   tick                   one-cycle game-tick enable; all state advances on it
//   place_btn              synchronised button level
//   player_x/player_y      player centre
//   bomb_x/bomb_y          latched bomb position
//   bomb_visible           blinking sprite enable while armed
//   blast_active           high throughout the blast
//   row_valid/row_idx      bomb horizontal corridor during blast
//   col_valid/col_idx      bomb vertical corridor during blast
//   busy                   bomb lifecycle in progress
//   player_hit             one-clk pulse, at most once per blast
module bomb_ctrl
   import bomb_pkg::*;
#(
   parameter int unsigned FUSE_TICKS     = FUSE_TICKS_DEF,
   parameter int unsigned BLAST_TICKS    = BLAST_TICKS_DEF,
   parameter int unsigned COOLDOWN_TICKS = COOLDOWN_TICKS_DEF,
   parameter int unsigned CW             = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick,
   input  logic          place_btn,
   input  logic [CW-1:0] player_x,
   input  logic [CW-1:0] player_y,
   output logic [CW-1:0] bomb_x,
   output logic [CW-1:0] bomb_y,
   output logic          bomb_visible,
   output logic          blast_active,
   output logic          row_valid,
   output logic [2:0]    row_idx,
   output logic          col_valid,
   output logic [2:0]    col_idx,
   output logic          busy,
   output logic          player_hit
);

   bomb_state_e      state, state_nxt;
   logic [CNT_W-1:0] fuse_cnt, fuse_nxt;
   logic [CNT_W-1:0] blast_cnt, blast_nxt;
   logic [CNT_W-1:0] cd_cnt, cd_nxt;
   logic             btn_prev, btn_prev_nxt;
   logic             hit_done, hit_done_nxt;
   logic [CW-1:0]    bomb_x_nxt, bomb_y_nxt;
   logic             bomb_visible_nxt, blast_active_nxt, busy_nxt, player_hit_nxt;
   logic             row_valid_nxt, col_valid_nxt;
   logic [2:0]       row_idx_nxt, col_idx_nxt;

   logic             place_req;
   logic             b_row_valid_c, b_col_valid_c, p_row_valid_c, p_col_valid_c;
   logic [2:0]       b_row_idx_c, b_col_idx_c, p_row_idx_c, p_col_idx_c;
   logic             hit_c;

   assign place_req = tick & place_btn & ~btn_prev;

   // Bomb position -> blast lanes
   lane_decode #(.CW(CW), .AXIS(LANE_ROW)) u_bomb_row (
      .coord(bomb_y), .valid_c(b_row_valid_c), .idx_c(b_row_idx_c));
   lane_decode #(.CW(CW), .AXIS(LANE_COL)) u_bomb_col (
      .coord(bomb_x), .valid_c(b_col_valid_c), .idx_c(b_col_idx_c));

   // Player position -> lanes, for the hit check
   lane_decode #(.CW(CW), .AXIS(LANE_ROW)) u_player_row (
      .coord(player_y), .valid_c(p_row_valid_c), .idx_c(p_row_idx_c));
   lane_decode #(.CW(CW), .AXIS(LANE_COL)) u_player_col (
      .coord(player_x), .valid_c(p_col_valid_c), .idx_c(p_col_idx_c));

   // Lanes are disjoint, so sharing an index means sharing the range
   assign hit_c = (row_valid & p_row_valid_c & (p_row_idx_c == row_idx)) |
                  (col_valid & p_col_valid_c & (p_col_idx_c == col_idx));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            ST_IDLE:     if (place_req) state_nxt = ST_ARMED;
            ST_ARMED:    if (fuse_cnt == CNT_W'(1)) state_nxt = ST_BLAST;
            ST_BLAST:    if (blast_cnt == CNT_W'(1))
                            state_nxt = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
            ST_COOLDOWN: if (cd_cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   // Counter, latch and output next values
   always_comb begin
      fuse_nxt       = fuse_cnt;
      blast_nxt      = blast_cnt;
      cd_nxt         = cd_cnt;
      btn_prev_nxt   = btn_prev;
      hit_done_nxt   = hit_done;
      bomb_x_nxt     = bomb_x;
      bomb_y_nxt     = bomb_y;
      row_valid_nxt  = row_valid;
      row_idx_nxt    = row_idx;
      col_valid_nxt  = col_valid;
      col_idx_nxt    = col_idx;
      player_hit_nxt = 1'b0;
      if (tick) begin
         btn_prev_nxt = place_btn;
         case (state)
            ST_IDLE: begin
               if (place_req) begin
                  bomb_x_nxt = player_x;
                  bomb_y_nxt = player_y;
                  fuse_nxt   = CNT_W'(FUSE_TICKS);
               end
            end
            ST_ARMED: begin
               fuse_nxt = fuse_cnt - CNT_W'(1);
               if (fuse_cnt == CNT_W'(1)) begin
                  blast_nxt     = CNT_W'(BLAST_TICKS);
                  row_valid_nxt = b_row_valid_c;
                  row_idx_nxt   = b_row_idx_c;
                  col_valid_nxt = b_col_valid_c;
                  col_idx_nxt   = b_col_idx_c;
                  hit_done_nxt  = 1'b0;
               end
            end
            ST_BLAST: begin
               blast_nxt = blast_cnt - CNT_W'(1);
               if (hit_c && !hit_done) begin
                  player_hit_nxt = 1'b1;
                  hit_done_nxt   = 1'b1;
               end
               if (blast_cnt == CNT_W'(1)) begin
                  cd_nxt        = CNT_W'(COOLDOWN_TICKS);
                  row_valid_nxt = 1'b0;
                  col_valid_nxt = 1'b0;
               end
            end
            ST_COOLDOWN: cd_nxt = cd_cnt - CNT_W'(1);
            default: ;
         endcase
      end
      // Flags follow the post-edge state so all outputs share one clk of latency
      busy_nxt         = (state_nxt != ST_IDLE);
      blast_active_nxt = (state_nxt == ST_BLAST);
      bomb_visible_nxt = (state_nxt == ST_ARMED) & ~fuse_nxt[3];
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fuse_cnt     <= '0;
         blast_cnt    <= '0;
         cd_cnt       <= '0;
         btn_prev     <= 1'b0;
         hit_done     <= 1'b0;
         bomb_x       <= '0;
         bomb_y       <= '0;
         bomb_visible <= 1'b0;
         blast_active <= 1'b0;
         row_valid    <= 1'b0;
         row_idx      <= 3'd0;
         col_valid    <= 1'b0;
         col_idx      <= 3'd0;
         busy         <= 1'b0;
         player_hit   <= 1'b0;
      end else begin
         fuse_cnt     <= fuse_nxt;
         blast_cnt    <= blast_nxt;
         cd_cnt       <= cd_nxt;
         btn_prev     <= btn_prev_nxt;
         hit_done     <= hit_done_nxt;
         bomb_x       <= bomb_x_nxt;
         bomb_y       <= bomb_y_nxt;
         bomb_visible <= bomb_visible_nxt;
         blast_active <= blast_active_nxt;
         row_valid    <= row_valid_nxt;
         row_idx      <= row_idx_nxt;
         col_valid    <= col_valid_nxt;
         col_idx      <= col_idx_nxt;
         busy         <= busy_nxt;
         player_hit   <= player_hit_nxt;
      end
   end

endmodule
